sc_mul_norm_seq: RTL and testbench

- Sequential, parametrised stochastic-computing (SC) unsigned multiplier with operand normalisation and valid/ready handshakes on both sides.
- Pipeline: leading-zero normalisation, truncation to VALID_BW MSBs, deterministic bitstream generation, AND-gate multiply, ones counting, then signed denormalising shift.
- Sits as a PE-level multiply unit in the SC-CGRA datapath; it is the handshaked successor to the combinational 16-bit SC multiplier.

---
 rtl/sc_mul_norm_seq_pkg.sv | 32 +++
 rtl/sc_mul_norm_seq_if.sv | 24 ++
 rtl/sc_mul_norm_seq_lzc.sv | 26 ++
 rtl/sc_mul_norm_seq.sv | 117 +++++++++++
 tb/tb_sc_mul_norm_seq.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_mul_norm_seq_pkg.sv
// Shared types and helpers for the stochastic-computing multiplier.
// Holds the FSM state enum, bit-reverse/clog2 helpers and the default geometry.
package sc_mul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    STREAM,
    SCALE,
    DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = v[n-1-i];
    return r;
  endfunction

  localparam int DATA_WIDTH_DEF = 16;
  localparam int VALID_BW_DEF   = 6;
  localparam int STREAM_LEN     = 1 << VALID_BW_DEF;
  localparam int SHIFT_W        = clog2(2 * DATA_WIDTH_DEF) + 2;

endpackage

// File: rtl/sc_mul_norm_seq_if.sv
// Operand/result handshake bundle for sc_mul_norm_seq.
// The master drives operands and consumes results; the slave is the multiplier.
interface sc_mul_norm_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 2 * DATA_WIDTH
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] io_inputs_a;
  logic [DATA_WIDTH-1:0] io_inputs_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_WIDTH-1:0]  mul_result;

  modport master (
    output in_valid, io_inputs_a, io_inputs_b, out_ready,
    input  in_ready, out_valid, mul_result
  );

  modport slave (
    input  in_valid, io_inputs_a, io_inputs_b, out_ready,
    output in_ready, out_valid, mul_result
  );
endinterface

// File: rtl/sc_mul_norm_seq_lzc.sv
// Parametrised combinational leading-zero counter.
// An all-zero input reports count 0 with all_zero set.
module sc_lzc
  import sc_mul_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW    = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CW-1:0]    count,
  output logic             all_zero
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count    = '0;
    all_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) begin
        count    = CW'(WIDTH - 1 - i);
        all_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sc_mul_norm_seq.sv
// Handshaked stochastic-computing unsigned multiplier with operand normalisation.
// Define SC_MUL_EARLY_TERM_EN to end the stream once the A bitstream is exhausted.
//
// state  | meaning
// IDLE   | waiting for an operand pair, in_ready high
// NORM   | sample leading-zero counts, keep VALID_BW MSBs of each operand
// STREAM | one bitstream position per cycle, count AND-ed ones
// SCALE  | denormalise the ones count by the signed shift
// DONE   | hold result with out_valid until out_ready
module sc_mul_norm_seq
  import sc_mul_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int VALID_BW   = VALID_BW_DEF,
  parameter int OUT_WIDTH  = 2 * DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  sc_mul_norm_seq_if.slave  bus,
  output logic              busy
);

  localparam int LZW = clog2(DATA_WIDTH);
  localparam int SW  = clog2(2 * DATA_WIDTH) + 2;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [LZW-1:0]        lza, lzb, lza_q, lzb_q;
  logic                  za, zb;
  logic [VALID_BW-1:0]   am_q, bm_q, cnt_q, ones_q;
  logic [OUT_WIDTH-1:0]  result_q;

  logic                  a_bit, b_bit, stream_last;
  logic signed [SW-1:0]  shift_s;
  logic [SW-1:0]         shift_mag;
  logic [OUT_WIDTH-1:0]  ones_ext, scaled;

  sc_lzc #(.WIDTH(DATA_WIDTH), .CW(LZW)) u_lzc_a (.data(a_q), .count(lza), .all_zero(za));
  sc_lzc #(.WIDTH(DATA_WIDTH), .CW(LZW)) u_lzc_b (.data(b_q), .count(lzb), .all_zero(zb));

  assign a_bit = cnt_q < am_q;
  assign b_bit = VALID_BW'(bitrev(32'(cnt_q), VALID_BW)) < bm_q;

`ifdef SC_MUL_EARLY_TERM_EN
  // a_bit is zero for every cnt >= A, so later cycles cannot add ones.
  assign stream_last = (cnt_q == am_q - VALID_BW'(1));
`else
  assign stream_last = (cnt_q == {VALID_BW{1'b1}});
`endif

  assign shift_s   = SW'(2 * DATA_WIDTH - VALID_BW - int'(lza_q) - int'(lzb_q));
  assign shift_mag = shift_s[SW-1] ? SW'(-shift_s) : SW'(shift_s);
  assign ones_ext  = OUT_WIDTH'(ones_q);
  assign scaled    = shift_s[SW-1] ? (ones_ext >> shift_mag) : (ones_ext << shift_mag);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A zero operand passes through SCALE with ones=0, giving a 0 result in two edges.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = NORM;
      NORM:    state_d = (za || zb) ? SCALE : STREAM;
      STREAM:  if (stream_last) state_d = SCALE;
      SCALE:   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      lza_q    <= '0;
      lzb_q    <= '0;
      am_q     <= '0;
      bm_q     <= '0;
      cnt_q    <= '0;
      ones_q   <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q <= bus.io_inputs_a;
            b_q <= bus.io_inputs_b;
          end
        end
        NORM: begin
          am_q   <= VALID_BW'((a_q << lza) >> (DATA_WIDTH - VALID_BW));
          bm_q   <= VALID_BW'((b_q << lzb) >> (DATA_WIDTH - VALID_BW));
          lza_q  <= lza;
          lzb_q  <= lzb;
          cnt_q  <= '0;
          ones_q <= '0;
        end
        STREAM: begin
          cnt_q  <= cnt_q + VALID_BW'(1);
          ones_q <= ones_q + VALID_BW'(a_bit & b_bit);
        end
        SCALE:   result_q <= scaled;
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.mul_result = result_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_sc_mul_norm_seq.sv
// Directed bench for sc_mul_norm_seq (DATA_WIDTH=16, VALID_BW=6).
// Latency expectations follow SC_MUL_EARLY_TERM_EN when it is defined.
module tb_sc_mul_norm_seq;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  sc_mul_norm_seq_if #(.DATA_WIDTH(16), .OUT_WIDTH(32)) bus ();

  sc_mul_norm_seq #(.DATA_WIDTH(16), .VALID_BW(6), .OUT_WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // a, b, expected product, normalised A, zero-operand flag
  logic [15:0] va [6];
  logic [15:0] vb [6];
  logic [31:0] vr [6];
  int          vn [6];
  bit          vz [6];

  function automatic int exp_lat(input int a_norm, input bit zero);
    if (zero) return 2;
`ifdef SC_MUL_EARLY_TERM_EN
    return a_norm + 2;
`else
    return 66;
`endif
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] res, output int lat);
    int n;
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.io_inputs_a = a;
    bus.io_inputs_b = b;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = bus.mul_result;
  endtask

  task automatic finish_op();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.io_inputs_a = '0;
    bus.io_inputs_b = '0;
    bus.out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    tests_run++;
    if (bus.mul_result !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_result got %h want 0", bus.mul_result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    logic [31:0] res;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], res, lat);
      tests_run++;
      if (res !== vr[i]) begin
        tests_failed++;
        $display("FAIL vec%0d_result a=%h b=%h got %h want %h", i, va[i], vb[i], res, vr[i]);
      end
      tests_run++;
      if (lat != exp_lat(vn[i], vz[i])) begin
        tests_failed++;
        $display("FAIL vec%0d_latency got %0d want %0d", i, lat, exp_lat(vn[i], vz[i]));
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    int          lat;
    run_op(16'h8000, 16'h8000, res, lat);
    tests_run++;
    if (res !== 32'h4000_0000) begin
      tests_failed++;
      $display("FAIL bp_result got %h want 40000000", res);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.mul_result !== 32'h4000_0000 || bus.in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold cycle%0d got valid=%b result=%h in_ready=%b want 1 40000000 0",
                 c, bus.out_valid, bus.mul_result, bus.in_ready);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_same_cycle_in_ready got %b want 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] res;
    int          lat;
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.io_inputs_a = 16'h8000;
    bus.io_inputs_b = 16'h8000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    // one NORM edge then twenty STREAM edges leaves cnt at 20
    repeat (21) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_busy_before got %b want 1", busy);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.mul_result !== 32'h0) begin
      tests_failed++;
      $display("FAIL midrst_abort got busy=%b valid=%b in_ready=%b result=%h want 0 0 1 0",
               busy, bus.out_valid, bus.in_ready, bus.mul_result);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h8000, 16'h8000, res, lat);
    tests_run++;
    if (res !== 32'h4000_0000) begin
      tests_failed++;
      $display("FAIL midrst_rerun_result got %h want 40000000", res);
    end
    tests_run++;
    if (lat != exp_lat(32, 1'b0)) begin
      tests_failed++;
      $display("FAIL midrst_rerun_latency got %0d want %0d", lat, exp_lat(32, 1'b0));
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int          lat;
    bus.out_ready = 1'b1;
    run_op(16'h0001, 16'h0001, res, lat);
    tests_run++;
    if (res !== 32'h0000_0001) begin
      tests_failed++;
      $display("FAIL b2b_first_result got %h want 00000001", res);
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_no_reaccept got in_ready=%b out_valid=%b want 0 1", bus.in_ready, bus.out_valid);
    end
    run_op(16'hFFFF, 16'hFFFF, res, lat);
    tests_run++;
    if (res !== 32'hFC00_0000) begin
      tests_failed++;
      $display("FAIL b2b_second_result got %h want fc000000", res);
    end
    tests_run++;
    if (lat != exp_lat(63, 1'b0)) begin
      tests_failed++;
      $display("FAIL b2b_second_latency got %0d want %0d", lat, exp_lat(63, 1'b0));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    va = '{16'h8000, 16'h0001, 16'h0000, 16'h1234, 16'hFFFF, 16'h00FF};
    vb = '{16'h8000, 16'h0001, 16'h1234, 16'h0000, 16'hFFFF, 16'h8000};
    vr = '{32'h4000_0000, 32'h0000_0001, 32'h0, 32'h0, 32'hFC00_0000, 32'h0080_0000};
    vn = '{32, 32, 0, 0, 63, 63};
    vz = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_midstream();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
